carbon_z80_top: RTL and testbench



---
 rtl/carbon_z80_top.sv | 131 +++++++++++++
 tb/tb_carbon_z80_top.sv | 131 +++++++++++++
 2 files changed

// File: rtl/carbon_z80_top.sv
// rtl/carbon_z80_top.sv - CarbonZ80 smoke-test sequencer with program ROM, RAM and I/O decode.
// Runs a fixed program that writes "Z80!" to the signature register and then powers off.
module carbon_z80_top #(
  parameter logic [7:0]  SIG_PORT_BASE = 8'h10,
  parameter logic [7:0]  POWEROFF_PORT = 8'hFF,
  parameter logic [15:0] RAM_BASE      = 16'h8000,
  parameter logic [7:0]  EXIT_CODE     = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] signature,
  output logic        poweroff
);

  typedef enum logic [1:0] {FETCH, OP1, OP2, HALTED} state_t;

  state_t      state;
  logic [15:0] pc;
  logic [7:0]  a;
  logic [7:0]  opcode;
  logic [7:0]  lo;
  logic [7:0]  ram [0:255];

  logic [7:0]  cur_byte;
  logic [7:0]  data_byte;
  logic [15:0] data_addr;
  logic [15:0] pc_off;
  logic [15:0] data_off;
  logic [7:0]  sig_k;

  // EXIT_CODE is the value sent to the power-off port; zero must leave poweroff clear.
  function automatic logic [7:0] rom_byte(input logic [7:0] addr);
    case (addr)
      8'h00: rom_byte = 8'h3E;  8'h01: rom_byte = 8'h5A;
      8'h02: rom_byte = 8'h32;  8'h03: rom_byte = 8'h00;  8'h04: rom_byte = 8'h80;
      8'h05: rom_byte = 8'h3E;  8'h06: rom_byte = 8'h00;
      8'h07: rom_byte = 8'h3A;  8'h08: rom_byte = 8'h00;  8'h09: rom_byte = 8'h80;
      8'h0A: rom_byte = 8'hD3;  8'h0B: rom_byte = 8'h10;
      8'h0C: rom_byte = 8'h3E;  8'h0D: rom_byte = 8'h38;
      8'h0E: rom_byte = 8'hD3;  8'h0F: rom_byte = 8'h11;
      8'h10: rom_byte = 8'h3E;  8'h11: rom_byte = 8'h30;
      8'h12: rom_byte = 8'hD3;  8'h13: rom_byte = 8'h12;
      8'h14: rom_byte = 8'h3E;  8'h15: rom_byte = 8'h21;
      8'h16: rom_byte = 8'hD3;  8'h17: rom_byte = 8'h13;
      8'h18: rom_byte = 8'h3E;  8'h19: rom_byte = EXIT_CODE;
      8'h1A: rom_byte = 8'hD3;  8'h1B: rom_byte = 8'hFF;
      8'h1C: rom_byte = 8'h76;
      default: rom_byte = 8'h00;
    endcase
  endfunction

  // Two combinational read ports: instruction stream at PC, data operand at {hi,lo}.
  always_comb begin
    pc_off = pc - RAM_BASE;
    if (pc[15:8] == 8'h00)
      cur_byte = rom_byte(pc[7:0]);
    else if (pc_off[15:8] == 8'h00)
      cur_byte = ram[pc_off[7:0]];
    else
      cur_byte = 8'h00;
    data_addr = {cur_byte, lo};
    data_off  = data_addr - RAM_BASE;
    if (data_addr[15:8] == 8'h00)
      data_byte = rom_byte(data_addr[7:0]);
    else if (data_off[15:8] == 8'h00)
      data_byte = ram[data_off[7:0]];
    else
      data_byte = 8'h00;
    sig_k = cur_byte - SIG_PORT_BASE;
  end

  always_ff @(posedge clk) begin
    if (!rst && state == OP2 && opcode == 8'h32 && data_off[15:8] == 8'h00)
      ram[data_off[7:0]] <= a;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= 16'h0000;
      a         <= 8'h00;
      opcode    <= 8'h00;
      lo        <= 8'h00;
      signature <= 32'h0;
      poweroff  <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          pc     <= pc + 16'd1;
          opcode <= cur_byte;
          case (cur_byte)
            8'h3E, 8'hD3, 8'h32, 8'h3A, 8'hC3: state <= OP1;
            8'h76:                             state <= HALTED;
            default:                           state <= FETCH;
          endcase
        end
        OP1: begin
          pc <= pc + 16'd1;
          case (opcode)
            8'h3E: begin
              a     <= cur_byte;
              state <= FETCH;
            end
            8'hD3: begin
              if (sig_k < 8'd4)
                signature[{sig_k[1:0], 3'b000} +: 8] <= a;
              if (cur_byte == POWEROFF_PORT && a != 8'h00)
                poweroff <= 1'b1;
              state <= FETCH;
            end
            default: begin
              lo    <= cur_byte;
              state <= OP2;
            end
          endcase
        end
        OP2: begin
          if (opcode == 8'hC3)
            pc <= data_addr;
          else
            pc <= pc + 16'd1;
          if (opcode == 8'h3A)
            a <= data_byte;
          state <= FETCH;
        end
        default: state <= HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_carbon_z80_top.sv
// tb/tb_carbon_z80_top.sv - randomized-reset bench for carbon_z80_top against an instruction-level model.
module tb_carbon_z80_top;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] sig0, sig1, sig2;
  logic        po0, po1, po2;

  int n_tests = 0;
  int n_fail  = 0;
  int c       = 0;

  logic [31:0] exp_sig [3][64];
  logic        exp_po  [3][64];
  logic [15:0] halt_pc [3];
  int          halt_cyc[3];

  always #5 clk = ~clk;

  // Default build, a variant that exits with 0, and a variant whose signature ports are unused.
  carbon_z80_top u0 (.clk(clk), .rst(rst), .signature(sig0), .poweroff(po0));
  carbon_z80_top #(.EXIT_CODE(8'h00)) u1 (.clk(clk), .rst(rst), .signature(sig1), .poweroff(po1));
  carbon_z80_top #(.SIG_PORT_BASE(8'h40)) u2 (.clk(clk), .rst(rst), .signature(sig2), .poweroff(po2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction-level interpreter producing the expected outputs after each post-reset edge.
  task automatic build_model(input int d, input logic [7:0] exit_code,
                             input logic [7:0] sig_base, input logic [7:0] po_port);
    logic [7:0]  prog [256];
    logic [7:0]  ram  [logic [15:0]];
    logic [7:0]  init [29] = '{8'h3E, 8'h5A, 8'h32, 8'h00, 8'h80, 8'h3E, 8'h00,
                              8'h3A, 8'h00, 8'h80, 8'hD3, 8'h10, 8'h3E, 8'h38,
                              8'hD3, 8'h11, 8'h3E, 8'h30, 8'hD3, 8'h12, 8'h3E,
                              8'h21, 8'hD3, 8'h13, 8'h3E, 8'h01, 8'hD3, 8'hFF, 8'h76};
    logic [15:0] pc, addr;
    logic [7:0]  a, op, port;
    logic [31:0] sig, old_sig;
    logic        po, old_po, halted;
    int          cyc, len;
    for (int i = 0; i < 256; i++) prog[i] = (i < 29) ? init[i] : 8'h00;
    prog[25] = exit_code;
    pc = 0; a = 0; sig = 0; po = 0; halted = 0; cyc = 0;
    exp_sig[d][0] = 0; exp_po[d][0] = 0;
    while (!halted && cyc < 56) begin
      old_sig = sig; old_po = po;
      op   = rd(prog, ram, pc);
      addr = {rd(prog, ram, pc + 16'd2), rd(prog, ram, pc + 16'd1)};
      len  = 1;
      case (op)
        8'h3E: begin a = rd(prog, ram, pc + 16'd1); len = 2; end
        8'hD3: begin
          port = rd(prog, ram, pc + 16'd1); len = 2;
          for (int k = 0; k < 4; k++)
            if (port == sig_base + 8'(k)) sig[8*k +: 8] = a;
          if (port == po_port && a != 0) po = 1;
        end
        8'h32: begin ram[addr] = a; len = 3; end
        8'h3A: begin a = rd(prog, ram, addr); len = 3; end
        8'h76: halted = 1;
        default: len = (op == 8'hC3) ? 3 : 1;
      endcase
      pc = (op == 8'hC3) ? addr : pc + 16'(len);
      for (int k = 1; k <= len; k++) begin
        exp_sig[d][cyc + k] = (k == len) ? sig : old_sig;
        exp_po[d][cyc + k]  = (k == len) ? po : old_po;
      end
      cyc += len;
    end
    halt_pc[d] = pc; halt_cyc[d] = cyc;
    for (int k = cyc + 1; k < 64; k++) begin
      exp_sig[d][k] = sig; exp_po[d][k] = po;
    end
  endtask

  function automatic logic [7:0] rd(input logic [7:0] prog [256], input logic [7:0] ram [logic [15:0]],
                                    input logic [15:0] addr);
    if (addr < 16'h0100) return prog[addr[7:0]];
    if (addr >= 16'h8000 && addr < 16'h8100) return ram.exists(addr) ? ram[addr] : 8'h00;
    return 8'h00;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) c = 0;
    else if (c < 63) c++;
    check($sformatf("sig0 c=%0d", c), sig0, exp_sig[0][c]);
    check($sformatf("po0 c=%0d", c),  {31'b0, po0}, {31'b0, exp_po[0][c]});
    check($sformatf("sig1 c=%0d", c), sig1, exp_sig[1][c]);
    check($sformatf("po1 c=%0d", c),  {31'b0, po1}, {31'b0, exp_po[1][c]});
    check($sformatf("sig2 c=%0d", c), sig2, exp_sig[2][c]);
    check($sformatf("po2 c=%0d", c),  {31'b0, po2}, {31'b0, exp_po[2][c]});
    if (!rst && c >= halt_cyc[0]) begin
      check("pc0 halted", {16'b0, u0.pc}, {16'b0, halt_pc[0]});
      check("pc1 halted", {16'b0, u1.pc}, {16'b0, halt_pc[1]});
      check("pc2 halted", {16'b0, u2.pc}, {16'b0, halt_pc[2]});
    end
  endtask

  initial begin
    build_model(0, 8'h01, 8'h10, 8'hFF);
    build_model(1, 8'h00, 8'h10, 8'hFF);
    build_model(2, 8'h01, 8'h40, 8'hFF);
    rst = 1'b1;
    repeat (10) tick();
    rst = 1'b0;
    repeat (40) tick();
    repeat (1000) tick();
    // Reset lands on edge 14, mid-program, then the run repeats from cycle 1.
    rst = 1'b1; tick();
    rst = 1'b0; repeat (13) tick();
    rst = 1'b1; tick();
    rst = 1'b0; repeat (35) tick();
    repeat (20) begin
      rst = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
      rst = 1'b0;
      repeat ($urandom_range(1, 45)) tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
